// File: rtl/key_pulse_pkg.sv
// Shared types and constants for the key debouncer / press-pulse generator.
// Latency: n/a (package). Backpressure: n/a.
package key_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    localparam int DEB_CYCLES_DEF = 16;

    // Counter must hold the value DEB_CYCLES itself, hence the +1.
    function automatic int cnt_width(input int deb_cycles);
        return $clog2(deb_cycles + 1);
    endfunction

endpackage

// File: rtl/key_pulse_if.sv
// Key input and debounced outputs; rel_pulse exists only with KEY_REL_PULSE_EN.
// Latency: n/a (wiring). Backpressure: none, outputs are fire-and-forget.
interface key_pulse_if;

    logic key_in;
    logic key_lvl;
    logic pulse;
`ifdef KEY_REL_PULSE_EN
    logic rel_pulse;

    modport master (output key_in, input key_lvl, input pulse, input rel_pulse);
    modport slave  (input key_in, output key_lvl, output pulse, output rel_pulse);
`else
    modport master (output key_in, input key_lvl, input pulse);
    modport slave  (input key_in, output key_lvl, output pulse);
`endif

endinterface

// File: rtl/key_pulse_sync2.sv
// Two-flop synchronizer for one asynchronous bit, reset to RST_VAL.
// Latency: 2 clk. Backpressure: none.
module sync2 #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_pulse.sv
// Debounces a raw key, outputs debounced level and one-cycle press pulse (release pulse with KEY_REL_PULSE_EN).
// Latency: pulse DEB_CYCLES+2 edges after first sampling edge. Backpressure: none.
module key_pulse
    import key_pulse_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter bit POL        = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    key_pulse_if.slave  kp
);

    localparam int CW = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          key_raw;
    logic          key_s;
    logic          press_evt;
    logic          rel_evt;
    logic          pulse_q;
    logic          lvl_q;

    sync2 #(
        .RST_VAL (!POL)
    ) u_sync2 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (kp.key_in),
        .q     (key_raw)
    );

    assign key_s = (key_raw == POL);

    // The sample that leaves IDLE/HELD already counts as sample 1.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press_evt = 1'b0;
        rel_evt   = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (key_s) begin
                    state_nxt = PRESS_CHK;
                    cnt_nxt   = CW'(1);
                end
            end
            PRESS_CHK: begin
                if (cnt >= CNT_DONE) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    press_evt = 1'b1;
                end else if (key_s) begin
                    cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            HELD: begin
                cnt_nxt = '0;
                if (!key_s) begin
                    state_nxt = REL_CHK;
                    cnt_nxt   = CW'(1);
                end
            end
            REL_CHK: begin
                if (cnt >= CNT_DONE) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    rel_evt   = 1'b1;
                end else if (!key_s) begin
                    cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
                end else begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Level is registered from the next state so it moves in the same cycle as the pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_q <= 1'b0;
            lvl_q   <= 1'b0;
        end else begin
            pulse_q <= press_evt;
            lvl_q   <= (state_nxt == HELD) || (state_nxt == REL_CHK);
        end
    end

    assign kp.pulse   = pulse_q;
    assign kp.key_lvl = lvl_q;

`ifdef KEY_REL_PULSE_EN
    logic rel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rel_q <= 1'b0;
        end else begin
            rel_q <= rel_evt;
        end
    end

    assign kp.rel_pulse = rel_q;
`else
    logic unused_rel;
    assign unused_rel = rel_evt;
`endif

endmodule

// File: tb/tb_key_pulse.sv
// Directed bench for key_pulse with DEB_CYCLES=4, POL=1; press pulse expected 7 cycles after input change.
module tb_key_pulse;

    localparam int DEB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    key_pulse_if kif ();

    key_pulse #(
        .DEB_CYCLES (DEB),
        .POL        (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kif.slave)
    );

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   pulse_cnt;
    int   pulse_at;
    int   rel_cnt;
    int   rel_at;
    int   base;
    bit   lvl_hi_seen;
    bit   lvl_lo_seen;
    bit   consec = 1'b0;
    logic prev_pulse = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic clr_stats();
        pulse_cnt   = 0;
        pulse_at    = -1;
        rel_cnt     = 0;
        rel_at      = -1;
        lvl_hi_seen = 1'b0;
        lvl_lo_seen = 1'b0;
    endtask

    // Advance one clock and sample outputs 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (kif.pulse === 1'b1) begin
            pulse_cnt++;
            pulse_at = cyc;
            if (prev_pulse === 1'b1) consec = 1'b1;
        end
        prev_pulse = kif.pulse;
        if (kif.key_lvl === 1'b1) lvl_hi_seen = 1'b1;
        else lvl_lo_seen = 1'b1;
`ifdef KEY_REL_PULSE_EN
        if (kif.rel_pulse === 1'b1) begin
            rel_cnt++;
            rel_at = cyc;
        end
`endif
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        kif.key_in = 1'b0;
        clr_stats();
        #2;
        rst_n = 1'b0;
        ticks(3);
        check_eq("reset_pulse", kif.pulse, 1'b0);
        check_eq("reset_lvl", kif.key_lvl, 1'b0);
        rst_n = 1'b1;
        ticks(3);

        // Clean press held 20 cycles
        clr_stats();
        kif.key_in = 1'b1;
        base = cyc;
        ticks(6);
        check_eq("press_early_pulse", kif.pulse, 1'b0);
        check_eq("press_early_lvl", kif.key_lvl, 1'b0);
        tick();
        check_eq("press_pulse", kif.pulse, 1'b1);
        check_eq("press_lvl", kif.key_lvl, 1'b1);
        tick();
        check_eq("press_pulse_width", kif.pulse, 1'b0);
        check_eq("press_lvl_hold", kif.key_lvl, 1'b1);
        ticks(12);
        check_eq("press_count", pulse_cnt, 1);
        check_eq("press_pos", pulse_at, base + 7);

        // Clean release
        clr_stats();
        kif.key_in = 1'b0;
        base = cyc;
        ticks(6);
        check_eq("rel_lvl_early", kif.key_lvl, 1'b1);
        tick();
        check_eq("rel_lvl_drop", kif.key_lvl, 1'b0);
`ifdef KEY_REL_PULSE_EN
        check_eq("rel_pulse", kif.rel_pulse, 1'b1);
`endif
        ticks(8);
        check_eq("rel_no_press", pulse_cnt, 0);
`ifdef KEY_REL_PULSE_EN
        check_eq("rel_count", rel_cnt, 1);
        check_eq("rel_pos", rel_at, base + 7);
`endif

        // Bounce: 2-cycle toggles, final rise at k=8
        clr_stats();
        for (int k = 0; k < 10; k++) begin
            kif.key_in = ((k / 2) % 2 == 0);
            if (k == 8) base = cyc;
            tick();
        end
        ticks(15);
        check_eq("bounce_count", pulse_cnt, 1);
        check_eq("bounce_pos", pulse_at, base + 7);
        kif.key_in = 1'b0;
        ticks(15);
        check_eq("bounce_rel_lvl", kif.key_lvl, 1'b0);

        // Glitch shorter than DEB
        clr_stats();
        kif.key_in = 1'b1;
        ticks(3);
        kif.key_in = 1'b0;
        ticks(15);
        check_eq("glitch_pulse", pulse_cnt, 0);
        check_eq("glitch_lvl", lvl_hi_seen, 1'b0);

        // Release bounce while held
        kif.key_in = 1'b1;
        ticks(10);
        check_eq("rb_held", kif.key_lvl, 1'b1);
        clr_stats();
        kif.key_in = 1'b0;
        ticks(3);
        kif.key_in = 1'b1;
        ticks(15);
        check_eq("rb_pulse", pulse_cnt, 0);
        check_eq("rb_lvl", lvl_lo_seen, 1'b0);
`ifdef KEY_REL_PULSE_EN
        check_eq("rb_rel", rel_cnt, 0);
`endif
        kif.key_in = 1'b0;
        ticks(15);

        // Reset after two counted samples
        clr_stats();
        kif.key_in = 1'b1;
        ticks(4);
        rst_n = 1'b0;
        #1;
        check_eq("rstmd_pulse", kif.pulse, 1'b0);
        check_eq("rstmd_lvl", kif.key_lvl, 1'b0);
        tick();
        rst_n = 1'b1;
        base = cyc;
        ticks(12);
        check_eq("rstmd_count", pulse_cnt, 1);
        check_eq("rstmd_pos", pulse_at, base + 7);

        // Asynchronous reset while held: level drops without a clock edge
        check_eq("async_pre_lvl", kif.key_lvl, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("async_lvl", kif.key_lvl, 1'b0);
        tick();
        rst_n = 1'b1;
        kif.key_in = 1'b0;
        ticks(5);

        check_eq("no_consec_pulse", consec, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_pulse.md
KEY_PULSE -- requirements
Module: key_pulse

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 16: consecutive stable samples needed to accept a level change; legal range is 2 or more.
REQ-002 SHALL have parameter POL, default 1: active level of key_in (1 = active-high, 0 = active-low).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port key_in, input, 1 bit: raw, asynchronous, bouncing key or switch.
REQ-006 SHALL have port key_lvl, output, 1 bit: debounced level, normalized so 1 = pressed.
REQ-007 SHALL have port pulse, output, 1 bit: single-cycle press pulse; drives the input of the downstream pulse stretcher.
REQ-008 SHALL have port rel_pulse, output, 1 bit: single-cycle release pulse; present only with the macro in REQ-021.

Function
REQ-009 SHALL pass key_in through a two-flop synchronizer and normalize the result to key_s (1 = active, per POL).
REQ-010 SHALL implement a state machine with four states:
- IDLE: key_s=1 -> PRESS_CHK.
- PRESS_CHK: key_s=1 counts; key_s=0 -> IDLE, counter cleared.
- HELD: key_s=0 -> REL_CHK.
- REL_CHK: key_s=0 counts; key_s=1 -> HELD, counter cleared.
REQ-011 SHALL count the sample seen in IDLE or HELD as sample 1; DEB_CYCLES consecutive matching samples complete PRESS_CHK -> HELD or REL_CHK -> IDLE.
REQ-012 SHALL register pulse high for exactly one cycle on the PRESS_CHK -> HELD transition.
- Latency: high after clock edge DEB_CYCLES+2, counting the first edge that samples key_in active as edge 0.
REQ-013 SHALL drive key_lvl=1 in HELD and REL_CHK and 0 otherwise; key_lvl rises in the same cycle as pulse.
REQ-014 SHALL saturate the counter (width clog2(DEB_CYCLES+1)); it never wraps.
REQ-015 SHALL ignore any run of fewer than DEB_CYCLES consecutive samples: no pulse and no key_lvl change.
REQ-016 SHALL never assert pulse in two consecutive cycles; successive pulses are at least 2*DEB_CYCLES cycles apart.
REQ-017 SHALL treat a key already held when reset releases as a new press: a pulse follows after the normal debounce.

Reset
REQ-018 SHALL, while rst_n=0, immediately and asynchronously force:
- state = IDLE;
- counter = 0;
- pulse, key_lvl and rel_pulse = 0;
- synchronizer flops to the inactive level (!POL).
REQ-019 SHALL, when reset is asserted mid-debounce, discard all partial count; counting restarts from IDLE after release.
REQ-020 SHALL resume operation on the first clock edge after rst_n deasserts.

Configuration
REQ-021 SHALL compile release detection in or out with the macro KEY_REL_PULSE_EN.
- Defined: rel_pulse is high for exactly one cycle on REL_CHK -> IDLE, with the same DEB_CYCLES+2 latency measured from the release.
- Undefined: the rel_pulse port and its logic are absent; all other behaviour is unchanged.

Structure
REQ-022 SHALL take from shared package key_pulse_pkg:
- the state enum typedef (IDLE, PRESS_CHK, HELD, REL_CHK);
- the default DEB_CYCLES constant;
- the counter-width function.
REQ-023 SHALL instantiate one sub-module, sync2: a two-flop synchronizer with a reset-value parameter, reusable elsewhere.

Verification (DEB_CYCLES=4, POL=1)
REQ-024 Clean press: key_in 0->1, held 20 cycles -> pulse high exactly 1 cycle, 6 edges after the first sampling edge; key_lvl 1 from that cycle.
REQ-025 Bounce: key_in toggles every 2 cycles for 10 cycles, then stays high -> exactly one pulse, 6 edges after the final rise.
REQ-026 Glitch: key_in high for 3 cycles, then low -> no pulse; key_lvl stays 0.
REQ-027 Release bounce: while HELD, key_in low 3 cycles then high again -> no new pulse; key_lvl stays 1 throughout.
REQ-028 Reset mid-debounce: rst_n low for 1 cycle after 2 counted samples, key_in held high -> outputs 0 at once; one pulse 6 edges after reset release.
REQ-029 Release with KEY_REL_PULSE_EN defined: press, hold, release -> rel_pulse high 1 cycle, 6 edges after the fall; key_lvl drops in the same cycle.
